// File: rtl/bit_iterator.sv
`default_nettype none
// ============================================================================
// bit_iterator : drains a bitmask one set bit per handshake, LSB- or MSB-first
// Revision: 1.0
// ============================================================================

module bit_iterator_lzc #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          MODE     = 1'b0,
    parameter int unsigned IdxWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]    in_i,
    output logic [IdxWidth-1:0] cnt_o,
    output logic                empty_o
);
    logic found;

    always_comb begin
        cnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!found && (MODE ? in_i[int'(WIDTH) - 1 - i] : in_i[i])) begin
                cnt_o = IdxWidth'(i);
                found = 1'b1;
            end
        end
        empty_o = ~found;
    end
endmodule

module bit_iterator #(
    parameter int unsigned WIDTH = 32,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned IdxWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [WIDTH-1:0]    mask_i,
    input  logic                mask_valid_i,
    output logic                mask_ready_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                idx_valid_o,
    input  logic                idx_ready_i,
    output logic                last_o,
    output logic                busy_o
);
    if (WIDTH < 1) begin : g_width_check
        $error("bit_iterator: WIDTH must be >= 1");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, ITER = 1'b1} state_t;

    state_t              state, state_next;
    logic [WIDTH-1:0]    pending, pending_next;
    logic [IdxWidth-1:0] cnt;
    logic [IdxWidth-1:0] enc_idx;
    logic                enc_empty;
    logic                single_bit;

    bit_iterator_lzc #(
        .WIDTH    (WIDTH),
        .MODE     (MODE),
        .IdxWidth (IdxWidth)
    ) i_lzc (
        .in_i    (pending),
        .cnt_o   (cnt),
        .empty_o (enc_empty)
    );

    // Leading-zero count is converted back to an absolute bit position.
    assign enc_idx    = MODE ? (IdxWidth'(WIDTH - 1) - cnt) : cnt;
    assign single_bit = ((pending & (pending - WIDTH'(1))) == '0) && !enc_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        idx_valid_o  = (state == ITER);
        idx_o        = idx_valid_o ? enc_idx : '0;
        last_o       = idx_valid_o & single_bit;
        busy_o       = (state == ITER);
        // Back-to-back: the final handshake frees the slot in the same cycle.
        mask_ready_o = !flush_i &&
                       ((state == IDLE) || (last_o && idx_ready_i));

        if (flush_i) begin
            state_next   = IDLE;
            pending_next = '0;
        end else begin
            if (idx_valid_o && idx_ready_i) begin
                pending_next = pending & ~(WIDTH'(1) << idx_o);
                if (last_o) begin
                    state_next = IDLE;
                end
            end
            if (mask_valid_i && mask_ready_o) begin
                pending_next = mask_i;
                state_next   = (|mask_i) ? ITER : IDLE;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bit_iterator.sv
`default_nettype none
// Testbench for bit_iterator: LSB-first and MSB-first instances share stimulus
// and are compared against a queue-based reference model.

module tb_bit_iterator;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [W-1:0] mask;
    logic         mask_valid;
    logic         idx_ready;

    logic         mr0, iv0, last0, busy0;
    logic         mr1, iv1, last1, busy1;
    logic [2:0]   idx0, idx1;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    bit_iterator #(.WIDTH(W), .MODE(1'b0)) dut_lsb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_i(mask),
        .mask_valid_i(mask_valid), .mask_ready_o(mr0), .idx_o(idx0),
        .idx_valid_o(iv0), .idx_ready_i(idx_ready), .last_o(last0), .busy_o(busy0)
    );

    bit_iterator #(.WIDTH(W), .MODE(1'b1)) dut_msb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_i(mask),
        .mask_valid_i(mask_valid), .mask_ready_o(mr1), .idx_o(idx1),
        .idx_valid_o(iv1), .idx_ready_i(idx_ready), .last_o(last1), .busy_o(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: list of set-bit positions in emission order for each mode.
    task automatic load_model(input logic [W-1:0] m);
        q0.delete();
        q1.delete();
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                q0.push_back(i);
                q1.push_front(i);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mr0"},   mr0,   1'b1);
        check({tag, "_mr1"},   mr1,   1'b1);
        check({tag, "_iv0"},   iv0,   1'b0);
        check({tag, "_iv1"},   iv1,   1'b0);
        check({tag, "_idx0"},  idx0,  0);
        check({tag, "_idx1"},  idx1,  0);
        check({tag, "_last0"}, last0, 1'b0);
        check({tag, "_last1"}, last1, 1'b0);
        check({tag, "_busy0"}, busy0, 1'b0);
        check({tag, "_busy1"}, busy1, 1'b0);
    endtask

    task automatic cycle(input logic mv, input logic [W-1:0] m, input logic ir, input logic fl);
        logic ev, el, emr;
        @(negedge clk);
        mask_valid = mv;
        mask       = m;
        idx_ready  = ir;
        flush      = fl;
        #1;
        ev  = (q0.size() != 0);
        el  = (q0.size() == 1);
        emr = !fl && (!ev || (el && ir));
        check("mask_ready0", mr0, emr);
        check("mask_ready1", mr1, emr);
        check("idx_valid0", iv0, ev);
        check("idx_valid1", iv1, ev);
        check("idx0", idx0, ev ? q0[0] : 0);
        check("idx1", idx1, ev ? q1[0] : 0);
        check("last0", last0, el);
        check("last1", last1, el);
        check("busy0", busy0, ev);
        check("busy1", busy1, ev);
        if (fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (ev && ir) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (mv && emr) load_model(m);
        end
    endtask

    task automatic idle_cycle(input logic ir);
        cycle(1'b0, '0, ir, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_mask();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'(1) << $urandom_range(0, W - 1);
            2:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        mask       = '0;
        mask_valid = 1'b0;
        idx_ready  = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Drain 1010_0110 with consumer always ready
        cycle(1'b1, 8'b1010_0110, 1'b1, 1'b0);
        repeat (5) idle_cycle(1'b1);

        // Backpressure
        cycle(1'b1, 8'b0001_0001, 1'b0, 1'b0);
        repeat (3) idle_cycle(1'b0);
        repeat (3) idle_cycle(1'b1);

        // Back-to-back masks with mask_valid held
        cycle(1'b1, 8'h80, 1'b1, 1'b0);
        cycle(1'b1, 8'h03, 1'b1, 1'b0);
        repeat (3) idle_cycle(1'b1);

        // Zero mask then a single-bit mask
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        idle_cycle(1'b1);
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        repeat (2) idle_cycle(1'b1);

        // Flush after two indices
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (2) idle_cycle(1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle_cycle(1'b1);

        // Asynchronous reset mid-iteration
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (2) idle_cycle(1'b1);
        @(negedge clk);
        mask_valid = 1'b0;
        idx_ready  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 2) != 0), rand_mask(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bit_iterator.md
# bit_iterator

Sequential scheduler that drains a bitmask one set bit per handshake. It accepts a `WIDTH`-bit mask and emits the index of each set bit in priority order, lowest first or highest first. It uses an instance of the codebase's leading/trailing zero counter as its priority encoder. The block serves as the issue sequencer wherever a request or valid vector must be serialised into indices, for example for TCDM bank replay or per-lane writeback.

## Interface
Parameters:
- `WIDTH`, default 32: mask width, must be ≥ 1; elaboration fails otherwise.
- `MODE`, default 1'b0: 0 emits from the LSB upward (trailing-zero order); 1 emits from the MSB downward (leading-zero order).
- `IdxWidth`, derived, not overridable: `WIDTH` > 1 ? $clog2(`WIDTH`) : 1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous abort of the current mask.
- `mask_i`  in  `WIDTH`  mask to iterate.
- `mask_valid_i`  in  1  `mask_i` is valid.
- `mask_ready_o`  out  1  block accepts a mask this cycle.
- `idx_o`  out  `IdxWidth`  bit index of the current set bit, in absolute position (not reversed for `MODE`=1).
- `idx_valid_o`  out  1  `idx_o` is valid.
- `idx_ready_i`  in  1  consumer accepts `idx_o`.
- `last_o`  out  1  current index is the final set bit of the mask; qualified by `idx_valid_o`.
- `busy_o`  out  1  a mask is being iterated (state ITER).

## Operation
- State: 2-state FSM (IDLE, ITER) plus a `WIDTH`-bit `pending` register.
- Priority encoder: a zero counter instance with `MODE` passed through operates on `pending`.
  - `MODE`=0: the count is the index directly.
  - `MODE`=1: index = `WIDTH`-1-count.
- IDLE:
  - `mask_ready_o`=1 (unless `flush_i`).
  - On `mask_valid_i` with a nonzero `mask_i`: load `pending`=`mask_i` and go to ITER.
  - On `mask_valid_i` with an all-zero `mask_i`: accept and discard the mask, stay in IDLE, emit no index.
- ITER:
  - `idx_valid_o`=1 and `idx_o`=encoder result.
  - `last_o`=1 iff `pending` has exactly one set bit, i.e. (`pending` & (`pending`-1))==0.
  - On `idx_ready_i`: clear bit `idx_o` in `pending`.
  - If `last_o` is also set: go to IDLE, with the back-to-back rule below taking precedence.
- Back-to-back: `mask_ready_o` = IDLE | (ITER & `last_o` & `idx_ready_i`).
  - A mask accepted in the same cycle as the final index handshake loads `pending` directly.
  - The FSM stays in ITER if that mask is nonzero; otherwise it goes to IDLE.
  - This is a combinational path from `idx_ready_i` to `mask_ready_o`. It is allowed and documented for integrators.
- Valid/ready rules:
  - `idx_valid_o`, `idx_o` and `last_o` never depend combinationally on `idx_ready_i`.
  - Once `idx_valid_o` is high, `idx_o` and `last_o` hold until the handshake or a flush.
  - `mask_i` is sampled only on a `mask_valid_i` & `mask_ready_o` handshake.
- Flush: `flush_i` has priority over everything.
  - Next state is IDLE and `pending` is cleared.
  - `mask_ready_o` is forced to 0 in the flush cycle.
  - An index presented in that cycle counts as dropped even if `idx_ready_i`=1.
- When `idx_valid_o`=0: `idx_o`=0 and `last_o`=0.
- `WIDTH`=1: `idx_o` is constant 0 and `last_o`=1 whenever valid.

## Timing
- Reset values: state=IDLE, `pending`=0, `mask_ready_o`=1, `idx_valid_o`=0, `idx_o`=0, `last_o`=0, `busy_o`=0.
- Latency: a mask accepted at edge N gives `idx_valid_o`=1 in the cycle after N with the first index.
- Throughput: one index per cycle while `idx_ready_i`=1.
  - A mask with P set bits drains in P cycles.
  - With back-to-back masks there are no bubbles.
- Asynchronous reset mid-iteration: immediate return to the reset values. Residual `pending` bits are lost.
- Critical path: `pending` → zero counter → one-hot clear → `pending`. It is a single cycle and no pipelining is required.

## Test plan
- `WIDTH`=8, `MODE`=0, mask 8'b1010_0110, `idx_ready_i`=1 → `idx_o` 1,2,5,7 on four consecutive cycles, `last_o` only with 7, then `mask_ready_o`=1.
- Same mask with `MODE`=1 → `idx_o` 7,5,2,1, `last_o` with 1.
- Backpressure: mask 8'b0001_0001, `idx_ready_i` low for 3 cycles → `idx_o`=0 and `last_o`=0 stable and valid throughout; after the handshake, `idx_o`=4 with `last_o`=1.
- Back-to-back: mask 8'h80, then mask 8'h03 presented with `mask_valid_i` held → `idx_o` 7,0,1 on three consecutive cycles, with 8'h03 accepted in the final-handshake cycle of 8'h80.
- Zero mask: mask 8'h00 accepted → `busy_o` stays 0, no `idx_valid_o`; next mask 8'h10 → `idx_o`=4 one cycle after acceptance.
- Flush and reset: mask 8'hFF, assert `flush_i` after two indices → next cycle `idx_valid_o`=0, `busy_o`=0, `mask_ready_o`=1. Repeat with `rst_ni` pulsed low mid-iteration → all outputs return to their reset values asynchronously.
